ram_dp_param_clr: RTL and testbench

- Parametrised successor of the COREABC 256x16 instruction/data RAM model.
- Simple dual-port memory: one write port and one read port on a single clock.
- Adds per-byte write enables, selectable read-during-write semantics, an optional output pipeline register and a hardware clear sweep.
- Used as the generic backing store for COREABC program RAM and digitizer scratch buffers; the sweep means software never reads uninitialised contents.

---
 rtl/ram_dp_param_clr_pkg.sv | 28 ++
 rtl/ram_dp_param_clr_if.sv | 32 +++
 rtl/ram_dp_param_clr_core.sv | 48 ++++
 rtl/ram_dp_param_clr.sv | 169 ++++++++++++++++
 tb/tb_ram_dp_param_clr.sv | 299 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/ram_dp_param_clr_pkg.sv
// ----------------------------------------------------------------------------
// ram_pkg: shared definitions for the ram_dp_param_clr memory slice.
//   state_e    - clear-sweep FSM states (ST_IDLE, ST_SWEEP)
//   lane_merge - selects the old byte or the write byte for one byte lane
//   cfg_ok     - elaboration-time parameter legality check
// ----------------------------------------------------------------------------
package ram_pkg;

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_SWEEP = 1'b1
    } state_e;

    function automatic logic [7:0] lane_merge(input logic [7:0] old_b,
                                              input logic [7:0] new_b,
                                              input logic       be);
        return be ? new_b : old_b;
    endfunction

    // DWIDTH must be a non-zero multiple of 8 and 1 <= DEPTH <= 2**AWIDTH.
    function automatic bit cfg_ok(input int unsigned dw,
                                  input int unsigned aw,
                                  input int unsigned depth);
        return (dw != 0) && (dw % 8 == 0) && (aw >= 1) && (aw < 32) &&
               (depth >= 1) && (longint'(depth) <= (longint'(1) << aw));
    endfunction

endpackage

// File: rtl/ram_dp_param_clr_if.sv
// ----------------------------------------------------------------------------
// ram_dp_param_clr_if: user-side bus of the dual-port RAM.
//   CLEAR/BUSY          - clear-sweep request and sweep-in-progress flag
//   WEN/WBE/WADDR/WD    - write port with per-byte enables
//   REN/RADDR/RD/RVALID - read port, RD holds between reads
// master = user logic, slave = the memory.
// ----------------------------------------------------------------------------
interface ram_dp_param_clr_if #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 8
);
    logic                  CLEAR;
    logic                  BUSY;
    logic                  WEN;
    logic [DWIDTH/8-1:0]   WBE;
    logic [AWIDTH-1:0]     WADDR;
    logic [DWIDTH-1:0]     WD;
    logic                  REN;
    logic [AWIDTH-1:0]     RADDR;
    logic [DWIDTH-1:0]     RD;
    logic                  RVALID;

    modport master (
        output CLEAR, WEN, WBE, WADDR, WD, REN, RADDR,
        input  BUSY, RD, RVALID
    );

    modport slave (
        input  CLEAR, WEN, WBE, WADDR, WD, REN, RADDR,
        output BUSY, RD, RVALID
    );
endinterface

// File: rtl/ram_dp_param_clr_core.sv
// ----------------------------------------------------------------------------
// ram_dp_core: bare simple dual-port array.
//   clk_i, rst_ni       - clock, async active-low reset (read register only)
//   we_i, wbe_i         - write strobe and byte-lane enables
//   waddr_i, wd_i       - write address/data (caller guarantees in range)
//   re_i, raddr_i       - read strobe/address (caller guarantees in range)
//   rd_o                - registered read data, held while re_i is low
// The array contents are never reset.
// ----------------------------------------------------------------------------
module ram_dp_core #(
    parameter int unsigned DWIDTH = 16,
    parameter int unsigned AWIDTH = 8,
    parameter int unsigned DEPTH  = 256
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                we_i,
    input  logic [DWIDTH/8-1:0] wbe_i,
    input  logic [AWIDTH-1:0]   waddr_i,
    input  logic [DWIDTH-1:0]   wd_i,
    input  logic                re_i,
    input  logic [AWIDTH-1:0]   raddr_i,
    output logic [DWIDTH-1:0]   rd_o
);
    logic [DWIDTH-1:0] mem_q [DEPTH];
    logic [DWIDTH-1:0] rd_q;

    always_ff @(posedge clk_i) begin
        if (we_i) begin
            for (int unsigned i = 0; i < DWIDTH/8; i++) begin
                if (wbe_i[i]) begin
                    mem_q[waddr_i][8*i +: 8] <= wd_i[8*i +: 8];
                end
            end
        end
    end

    // Read-before-write: a same-address write lands after this sample.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rd_q <= '0;
        end else if (re_i) begin
            rd_q <= mem_q[raddr_i];
        end
    end

    assign rd_o = rd_q;
endmodule

// File: rtl/ram_dp_param_clr.sv
// ----------------------------------------------------------------------------
// ram_dp_param_clr: parametrised dual-port RAM with hardware clear sweep.
//   RWCLK  - single clock, rising edge
//   RESET  - asynchronous active-low reset; starts a clear sweep
//   bus    - ram_dp_param_clr_if slave: CLEAR/BUSY, write port
//            (WEN/WBE/WADDR/WD), read port (REN/RADDR/RD/RVALID)
// The top owns the sweep FSM, address range checks, the read-during-write
// bypass and the optional output register; storage lives in ram_dp_core.
// ----------------------------------------------------------------------------
module ram_dp_param_clr
    import ram_pkg::*;
#(
    parameter int unsigned       DWIDTH    = 16,
    parameter int unsigned       AWIDTH    = 8,
    parameter int unsigned       DEPTH     = 256,
    parameter int unsigned       RDW_MODE  = 0,
    parameter int unsigned       OUT_REG   = 0,
    parameter logic [DWIDTH-1:0] CLR_VALUE = '0
) (
    input logic                 RWCLK,
    input logic                 RESET,
    ram_dp_param_clr_if.slave   bus
);
    localparam int unsigned NLANE = DWIDTH / 8;

    if (!cfg_ok(DWIDTH, AWIDTH, DEPTH)) begin : g_cfg_err
        $error("ram_dp_param_clr: DWIDTH must be a multiple of 8 and 1 <= DEPTH <= 2**AWIDTH");
    end

    state_e             state_q;
    logic [AWIDTH-1:0]  cnt_q;
    logic               busy_q;

    logic               waddr_in, raddr_in, wr_ok, rd_fire;
    logic               core_we, core_re;
    logic [NLANE-1:0]   core_wbe;
    logic [AWIDTH-1:0]  core_waddr;
    logic [DWIDTH-1:0]  core_wd, core_rd;

    logic               rv1_q, oor1_q, byp1_q;
    logic [DWIDTH-1:0]  bwd1_q;
    logic [NLANE-1:0]   bwbe1_q;
    logic [DWIDTH-1:0]  rd1_data;

    // One extra bit so DEPTH == 2**AWIDTH compares without overflow.
    assign waddr_in = ({1'b0, bus.WADDR} < (AWIDTH+1)'(DEPTH));
    assign raddr_in = ({1'b0, bus.RADDR} < (AWIDTH+1)'(DEPTH));
    assign wr_ok    = bus.WEN & ~busy_q & waddr_in;
    assign rd_fire  = bus.REN & ~busy_q;

    // Clear-sweep FSM; busy_q is the registered BUSY output.
    always_ff @(posedge RWCLK or negedge RESET) begin
        if (!RESET) begin
            state_q <= ST_SWEEP;
            cnt_q   <= '0;
            busy_q  <= 1'b1;
        end else begin
            unique case (state_q)
                ST_SWEEP: begin
                    // Stop on the last index so a full 2**AWIDTH array never wraps.
                    if (cnt_q == AWIDTH'(DEPTH - 1)) begin
                        state_q <= ST_IDLE;
                        busy_q  <= 1'b0;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                ST_IDLE: begin
                    if (bus.CLEAR) begin
                        state_q <= ST_SWEEP;
                        cnt_q   <= '0;
                        busy_q  <= 1'b1;
                    end
                end
            endcase
        end
    end

    // The sweep owns the write port; user accesses are dropped while busy.
    always_comb begin
        core_we    = wr_ok;
        core_wbe   = bus.WBE;
        core_waddr = bus.WADDR;
        core_wd    = bus.WD;
        if (busy_q) begin
            core_we    = 1'b1;
            core_wbe   = '1;
            core_waddr = cnt_q;
            core_wd    = CLR_VALUE;
        end
    end

    assign core_re = rd_fire & raddr_in;

    ram_dp_core #(
        .DWIDTH (DWIDTH),
        .AWIDTH (AWIDTH),
        .DEPTH  (DEPTH)
    ) u_core (
        .clk_i   (RWCLK),
        .rst_ni  (RESET),
        .we_i    (core_we),
        .wbe_i   (core_wbe),
        .waddr_i (core_waddr),
        .wd_i    (core_wd),
        .re_i    (core_re),
        .raddr_i (bus.RADDR),
        .rd_o    (core_rd)
    );

    // Side information for the word the core is returning; captured only on
    // a read so that RD keeps its value between reads.
    always_ff @(posedge RWCLK or negedge RESET) begin
        if (!RESET) begin
            rv1_q   <= 1'b0;
            oor1_q  <= 1'b0;
            byp1_q  <= 1'b0;
            bwd1_q  <= '0;
            bwbe1_q <= '0;
        end else begin
            rv1_q <= rd_fire;
            if (rd_fire) begin
                oor1_q  <= ~raddr_in;
                byp1_q  <= (RDW_MODE != 0) && wr_ok && (bus.WADDR == bus.RADDR);
                bwd1_q  <= bus.WD;
                bwbe1_q <= bus.WBE;
            end
        end
    end

    // The core sampled the pre-write word; new-data mode overlays the
    // written lanes afterwards instead of forwarding inside the array.
    always_comb begin
        rd1_data = core_rd;
        if (byp1_q) begin
            for (int unsigned i = 0; i < NLANE; i++) begin
                rd1_data[8*i +: 8] = lane_merge(core_rd[8*i +: 8], bwd1_q[8*i +: 8], bwbe1_q[i]);
            end
        end
        if (oor1_q) begin
            rd1_data = '0;
        end
    end

    if (OUT_REG != 0) begin : g_oreg
        logic [DWIDTH-1:0] rd2_q;
        logic              rv2_q;

        always_ff @(posedge RWCLK or negedge RESET) begin
            if (!RESET) begin
                rd2_q <= '0;
                rv2_q <= 1'b0;
            end else begin
                rv2_q <= rv1_q;
                if (rv1_q) begin
                    rd2_q <= rd1_data;
                end
            end
        end

        assign bus.RD     = rd2_q;
        assign bus.RVALID = rv2_q;
    end else begin : g_noreg
        assign bus.RD     = rd1_data;
        assign bus.RVALID = rv1_q;
    end

    assign bus.BUSY = busy_q;
endmodule

// File: tb/tb_ram_dp_param_clr.sv
// ----------------------------------------------------------------------------
// tb_ram_dp_param_clr: three configurations driven with identical stimulus
//   u0: DEPTH 256, old-data RDW, no output reg, CLR 16'hA5A5
//   u1: DEPTH 256, new-data RDW, output reg,    CLR 16'h3C3C
//   u2: DEPTH 200, old-data RDW, no output reg, CLR 16'h0F0F
// Each is compared every cycle against a word-array reference model.
// ----------------------------------------------------------------------------
module tb_ram_dp_param_clr;
    localparam int unsigned NDUT = 3;
    localparam int unsigned DEP  [NDUT] = '{256, 256, 200};
    localparam int unsigned RDWM [NDUT] = '{0, 1, 0};
    localparam int unsigned OREG [NDUT] = '{0, 1, 0};
    localparam logic [15:0] CLRV [NDUT] = '{16'hA5A5, 16'h3C3C, 16'h0F0F};

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        clear, wen, ren;
    logic [1:0]  wbe;
    logic [7:0]  waddr, raddr;
    logic [15:0] wd;

    logic        busy_o   [NDUT];
    logic        rvalid_o [NDUT];
    logic [15:0] rd_o     [NDUT];

    always #5 clk = ~clk;

    for (genvar g = 0; g < NDUT; g++) begin : g_dut
        ram_dp_param_clr_if #(.DWIDTH(16), .AWIDTH(8)) bus ();

        assign bus.CLEAR = clear;
        assign bus.WEN   = wen;
        assign bus.WBE   = wbe;
        assign bus.WADDR = waddr;
        assign bus.WD    = wd;
        assign bus.REN   = ren;
        assign bus.RADDR = raddr;
        assign busy_o[g]   = bus.BUSY;
        assign rvalid_o[g] = bus.RVALID;
        assign rd_o[g]     = bus.RD;

        ram_dp_param_clr #(
            .DWIDTH    (16),
            .AWIDTH    (8),
            .DEPTH     (DEP[g]),
            .RDW_MODE  (RDWM[g]),
            .OUT_REG   (OREG[g]),
            .CLR_VALUE (CLRV[g])
        ) u_dut (
            .RWCLK (clk),
            .RESET (rst_n),
            .bus   (bus)
        );
    end

    // Reference model: plain word arrays, a sweep position and a result queue
    // of depth 0 or 1 depending on read latency.
    logic [15:0] mem_m  [NDUT][256];
    bit          busy_m [NDUT];
    int unsigned pos_m  [NDUT];
    bit          pend_v [NDUT];
    logic [15:0] pend_d [NDUT];
    bit          exp_rv [NDUT];
    logic [15:0] exp_rd [NDUT];

    int unsigned n_checks = 0;
    int unsigned n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s t=%0t got %h expected %h", tag, $time, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            busy_m[k] = 1'b1;
            pos_m[k]  = 0;
            pend_v[k] = 1'b0;
            pend_d[k] = '0;
            exp_rv[k] = 1'b0;
            exp_rd[k] = '0;
        end
    endtask

    task automatic model_step();
        bit          nv;
        logic [15:0] nd;
        for (int k = 0; k < NDUT; k++) begin
            nv = 1'b0;
            nd = '0;
            if (busy_m[k]) begin
                mem_m[k][pos_m[k]] = CLRV[k];
                pos_m[k]++;
                if (pos_m[k] == DEP[k]) busy_m[k] = 1'b0;
            end else begin
                if (ren) begin
                    nv = 1'b1;
                    if (raddr < DEP[k]) begin
                        nd = mem_m[k][raddr];
                        if (RDWM[k] == 1 && wen && waddr == raddr) begin
                            if (wbe[0]) nd[7:0]  = wd[7:0];
                            if (wbe[1]) nd[15:8] = wd[15:8];
                        end
                    end
                end
                if (wen && waddr < DEP[k]) begin
                    if (wbe[0]) mem_m[k][waddr][7:0]  = wd[7:0];
                    if (wbe[1]) mem_m[k][waddr][15:8] = wd[15:8];
                end
                if (clear) begin
                    busy_m[k] = 1'b1;
                    pos_m[k]  = 0;
                end
            end
            if (OREG[k] == 1) begin
                exp_rv[k] = pend_v[k];
                if (pend_v[k]) exp_rd[k] = pend_d[k];
                pend_v[k] = nv;
                pend_d[k] = nd;
            end else begin
                exp_rv[k] = nv;
                if (nv) exp_rd[k] = nd;
            end
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NDUT; k++) begin
            chk($sformatf("busy[%0d]", k),   32'(busy_o[k]),   32'(busy_m[k]));
            chk($sformatf("rvalid[%0d]", k), 32'(rvalid_o[k]), 32'(exp_rv[k]));
            chk($sformatf("rd[%0d]", k),     32'(rd_o[k]),     32'(exp_rd[k]));
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        if (rst_n) model_step();
        else       model_reset();
        #1;
        check_all();
    endtask

    task automatic set_in(input logic we, input logic [1:0] be, input logic [7:0] wa,
                          input logic [15:0] d, input logic re, input logic [7:0] ra,
                          input logic clr);
        wen = we; wbe = be; waddr = wa; wd = d; ren = re; raddr = ra; clear = clr;
    endtask

    task automatic idle_in();
        set_in(1'b0, 2'b00, 8'h00, 16'h0000, 1'b0, 8'h00, 1'b0);
    endtask

    task automatic op(input logic we, input logic [1:0] be, input logic [7:0] wa,
                      input logic [15:0] d, input logic re, input logic [7:0] ra,
                      input logic clr);
        set_in(we, be, wa, d, re, ra, clr);
        cyc();
    endtask

    task automatic rand_in(input bit allow_clear);
        set_in(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 8'($urandom_range(0, 255)),
               16'($urandom), 1'($urandom_range(0, 1)), 8'($urandom_range(0, 255)),
               allow_clear && ($urandom_range(0, 299) == 0));
        if ($urandom_range(0, 3) == 0) raddr = waddr;
    endtask

    // Counts edges until each DUT drops BUSY; optionally fires accesses while
    // every DUT is still sweeping.
    task automatic wait_idle(input bit noisy);
        int unsigned cnt [NDUT];
        bit          low [NDUT];
        bit          all_low;
        for (int k = 0; k < NDUT; k++) begin
            cnt[k] = 0;
            low[k] = 1'b0;
        end
        for (int i = 0; i < 600; i++) begin
            all_low = 1'b1;
            for (int k = 0; k < NDUT; k++) if (!low[k]) all_low = 1'b0;
            if (all_low) break;
            if (noisy && busy_m[0] && busy_m[1] && busy_m[2]) rand_in(1'b0);
            else idle_in();
            cyc();
            for (int k = 0; k < NDUT; k++) begin
                if (!low[k]) begin
                    cnt[k]++;
                    if (!busy_o[k]) low[k] = 1'b1;
                end
            end
        end
        idle_in();
        for (int k = 0; k < NDUT; k++) chk($sformatf("busy_len[%0d]", k), cnt[k], DEP[k]);
    endtask

    initial begin
        logic [7:0] a;
        idle_in();
        model_reset();

        // Reset state while RESET is held low.
        cyc();
        cyc();
        rst_n = 1'b1;
        wait_idle(1'b0);

        // Sweep contents.
        op(0, 2'b00, 8'h00, 16'h0, 1, 8'h00, 0);
        chk("sweep_rd00", 32'(rd_o[0]), 32'h0000_A5A5);
        chk("sweep_rv00", 32'(rvalid_o[0]), 32'h1);
        op(0, 2'b00, 8'h00, 16'h0, 1, 8'h7F, 0);
        chk("sweep_rd7f", 32'(rd_o[0]), 32'h0000_A5A5);
        op(0, 2'b00, 8'h00, 16'h0, 1, 8'hFF, 0);
        chk("sweep_rdff", 32'(rd_o[0]), 32'h0000_A5A5);
        chk("sweep_oorff", 32'(rd_o[2]), 32'h0);
        idle_in(); cyc(); cyc();

        // Byte enables.
        op(1, 2'b11, 8'h10, 16'h1234, 0, 8'h00, 0);
        op(1, 2'b01, 8'h10, 16'hABCD, 0, 8'h00, 0);
        op(0, 2'b00, 8'h00, 16'h0, 1, 8'h10, 0);
        chk("wbe_rd", 32'(rd_o[0]), 32'h0000_12CD);
        idle_in(); cyc();
        chk("wbe_rd_oreg", 32'(rd_o[1]), 32'h0000_12CD);

        // Read during write.
        op(1, 2'b11, 8'h20, 16'h0000, 0, 8'h00, 0);
        op(1, 2'b10, 8'h20, 16'hBEEF, 1, 8'h20, 0);
        chk("rdw_old", 32'(rd_o[0]), 32'h0);
        chk("rdw_old_d200", 32'(rd_o[2]), 32'h0);
        idle_in(); cyc();
        chk("rdw_new", 32'(rd_o[1]), 32'h0000_BE00);
        cyc();

        // Output register: back-to-back reads.
        op(1, 2'b11, 8'h01, 16'h1111, 0, 8'h00, 0);
        op(1, 2'b11, 8'h02, 16'h2222, 0, 8'h00, 0);
        op(1, 2'b11, 8'h03, 16'h3333, 0, 8'h00, 0);
        op(0, 2'b00, 8'h00, 16'h0, 1, 8'h01, 0);
        chk("oreg_lat_rv", 32'(rvalid_o[1]), 32'h0);
        op(0, 2'b00, 8'h00, 16'h0, 1, 8'h02, 0);
        chk("oreg_rd1", 32'(rd_o[1]), 32'h0000_1111);
        op(0, 2'b00, 8'h00, 16'h0, 1, 8'h03, 0);
        chk("oreg_rd2", 32'(rd_o[1]), 32'h0000_2222);
        idle_in(); cyc();
        chk("oreg_rd3", 32'(rd_o[1]), 32'h0000_3333);
        chk("oreg_rv3", 32'(rvalid_o[1]), 32'h1);
        cyc();
        chk("oreg_rv_end", 32'(rvalid_o[1]), 32'h0);

        // CLEAR sweep.
        op(1, 2'b11, 8'h05, 16'h0055, 0, 8'h00, 0);
        op(0, 2'b00, 8'h00, 16'h0, 0, 8'h00, 1);
        wait_idle(1'b0);
        op(0, 2'b00, 8'h00, 16'h0, 1, 8'h05, 0);
        chk("clear_rd05", 32'(rd_o[2]), 32'h0000_0F0F);

        // Out-of-range on the 200-word instance.
        op(1, 2'b11, 8'hC8, 16'h1234, 0, 8'h00, 0);
        op(0, 2'b00, 8'h00, 16'h0, 1, 8'hC8, 0);
        chk("oor_rd", 32'(rd_o[2]), 32'h0);
        chk("oor_rv", 32'(rvalid_o[2]), 32'h1);
        chk("inrange_c8", 32'(rd_o[0]), 32'h0000_1234);
        op(0, 2'b00, 8'h00, 16'h0, 1, 8'h48, 0);
        chk("no_alias", 32'(rd_o[2]), 32'h0000_0F0F);
        idle_in(); cyc();

        // Reset 50 cycles into a sweep, then accesses during the restarted sweep.
        op(0, 2'b00, 8'h00, 16'h0, 0, 8'h00, 1);
        idle_in();
        repeat (50) cyc();
        rst_n = 1'b0;
        model_reset();
        #1;
        check_all();
        cyc();
        rst_n = 1'b1;
        wait_idle(1'b1);
        for (int i = 0; i < 4; i++) begin
            a = 8'($urandom_range(0, 199));
            op(0, 2'b00, 8'h00, 16'h0, 1, a, 0);
            chk("no_late_wr0", 32'(rd_o[0]), 32'h0000_A5A5);
            chk("no_late_wr2", 32'(rd_o[2]), 32'h0000_0F0F);
        end

        // Randomised traffic with occasional CLEAR.
        for (int i = 0; i < 3000; i++) begin
            rand_in(1'b1);
            cyc();
        end
        idle_in();
        repeat (3) cyc();

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end
endmodule
